// File: rtl/bcd_mod_invcounter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_mod_invcounter_pkg
// Shared types, constants and BCD helpers for the two-digit BCD time-field
// engine (complement decoder / countdown counter).
//   bcd_digit_t : one BCD digit
//   bcd2_t      : two-digit BCD value {dec, uni}
//   state_e     : engine state (CONV, HALT, RUN)
//   bcd2bin()   : two BCD digits -> binary 0..99
//   bin2bcd()   : binary 0..99   -> two BCD digits
// ---------------------------------------------------------------------------
package bcd_mod_invcounter_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t dec;
    bcd_digit_t uni;
  } bcd2_t;

  typedef enum logic [1:0] {
    CONV = 2'd0,
    HALT = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int MOD_HOURS  = 24;
  localparam int MOD_MINSEC = 60;

  // Caller guarantees both digits are <= 9, so the result fits in 7 bits.
  function automatic logic [6:0] bcd2bin(input bcd_digit_t dec, input bcd_digit_t uni);
    logic [7:0] acc;
    acc = ({4'd0, dec} << 3) + ({4'd0, dec} << 1) + {4'd0, uni};
    return acc[6:0];
  endfunction

  // Caller guarantees bin <= 99, so both digits are valid BCD.
  function automatic bcd2_t bin2bcd(input logic [6:0] bin);
    bcd2_t r;
    r.dec = 4'(bin / 7'd10);
    r.uni = 4'(bin % 7'd10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_invcounter_if.sv
// ---------------------------------------------------------------------------
// bcd_mod_invcounter_if
// Bundles the data/control inputs and status outputs of the engine.
//   code_dec/code_uni : input value, BCD
//   mode              : 0 = convert, 1 = count
//   load/en/tick      : counter controls (count mode only)
//   outdec/outuni     : registered output value, BCD
//   err/borrow        : 1-cycle status pulses
//   done/zero         : status levels
// master drives the inputs; slave is the engine itself.
// ---------------------------------------------------------------------------
interface bcd_mod_invcounter_if;
  import bcd_mod_invcounter_pkg::*;

  bcd_digit_t code_dec;
  bcd_digit_t code_uni;
  logic       mode;
  logic       load;
  logic       en;
  logic       tick;
  bcd_digit_t outdec;
  bcd_digit_t outuni;
  logic       err;
  logic       borrow;
  logic       done;
  logic       zero;

  modport master (
    output code_dec, code_uni, mode, load, en, tick,
    input  outdec, outuni, err, borrow, done, zero
  );

  modport slave (
    input  code_dec, code_uni, mode, load, en, tick,
    output outdec, outuni, err, borrow, done, zero
  );

endinterface

// File: rtl/bcd_mod_invcounter_bcd2_down_counter.sv
// ---------------------------------------------------------------------------
// bcd2_down_counter
// Two-digit BCD down-counter with load, decrement and modulus wrap.
//   clk, reset    : clock, async active-high reset (count -> 00)
//   load_i        : capture load_val_i (already legality-checked by caller)
//   load_val_i    : value to load, BCD
//   dec_i         : decrement strobe (ignored when load_i is high)
//   count_o       : registered count
//   count_nxt_o   : count after this cycle's update, lets the parent register
//                   its outputs in step with the count
//   at_zero_o     : registered count equals 00
//   borrow_o      : this cycle's decrement wraps 00 -> MOD-1 (WRAP=1 only)
// ---------------------------------------------------------------------------
module bcd2_down_counter
  import bcd_mod_invcounter_pkg::*;
#(
  parameter int MOD  = MOD_HOURS,
  parameter bit WRAP = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  bcd2_t load_val_i,
  input  logic  dec_i,
  output bcd2_t count_o,
  output bcd2_t count_nxt_o,
  output logic  at_zero_o,
  output logic  borrow_o
);

  localparam bcd2_t TOP_VAL = bin2bcd(7'(MOD - 1));

  bcd2_t count_q;
  bcd2_t count_d;
  logic  wrap_s;

  // Next count: load wins over decrement; 00 either wraps or holds.
  always_comb begin
    count_d = count_q;
    wrap_s  = 1'b0;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      if (count_q == 8'h00) begin
        if (WRAP) begin
          count_d = TOP_VAL;
          wrap_s  = 1'b1;
        end else begin
          count_d = count_q;
        end
      end else if (count_q.uni == 4'd0) begin
        count_d.uni = 4'd9;
        count_d.dec = count_q.dec - 4'd1;
      end else begin
        count_d.uni = count_q.uni - 4'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign at_zero_o   = (count_q == 8'h00);
  assign borrow_o    = wrap_s;

endmodule

// File: rtl/bcd_mod_invcounter.sv
// ---------------------------------------------------------------------------
// bcd_mod_invcounter
// Two-digit BCD time-field engine. Mode 0 outputs the registered complement
// of the input with respect to the modulus (MOD-1-in); mode 1 is a loadable
// BCD countdown timer with wrap/stop policy.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of bcd_mod_invcounter_if (inputs, controls,
//                registered outputs and status flags)
// Parameters: MOD (2..100) field modulus, WRAP (1 = wrap at 00, 0 = halt).
// ---------------------------------------------------------------------------
module bcd_mod_invcounter
  import bcd_mod_invcounter_pkg::*;
#(
  parameter int MOD  = MOD_HOURS,
  parameter bit WRAP = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  bcd_mod_invcounter_if.slave  bus
);

  localparam logic [7:0] MOD_W   = 8'(MOD);
  localparam logic [6:0] MAX_BIN = 7'(MOD - 1);

  state_e     state_q, state_d;
  bcd2_t      out_q, out_d;
  logic       err_q, err_d;
  logic       borrow_q, borrow_d;
  logic       done_q, done_d;
  logic       zero_q;

  bcd2_t      in_s;
  logic [6:0] in_bin_s;
  logic       legal_s;
  logic       counting_s;
  logic       cnt_load_s;
  logic       cnt_dec_s;
  bcd2_t      cnt_s;
  bcd2_t      cnt_nxt_s;
  logic       cnt_zero_s;
  logic       cnt_borrow_s;
  logic       stop_s;

  assign in_s     = {bus.code_dec, bus.code_uni};
  assign in_bin_s = bcd2bin(in_s.dec, in_s.uni);
  // Digit check comes first: the binary value is meaningless for non-BCD digits.
  assign legal_s  = (in_s.dec <= 4'd9) && (in_s.uni <= 4'd9) && ({1'b0, in_bin_s} < MOD_W);

  // load/tick only act once the engine has settled into HALT or RUN.
  assign counting_s = bus.mode && (state_q != CONV);
  assign cnt_load_s = counting_s && bus.load && legal_s;
  // Any load (even an illegal one) drops a coincident tick.
  assign cnt_dec_s  = bus.mode && (state_q == RUN) && bus.en && bus.tick && !bus.load;
  // Without wrap, a tick that leaves the count at 00 stops the run.
  assign stop_s     = cnt_dec_s && !WRAP && (cnt_zero_s || (cnt_s == 8'h01));

  bcd2_down_counter #(
    .MOD  (MOD),
    .WRAP (WRAP)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .load_i      (cnt_load_s),
    .load_val_i  (in_s),
    .dec_i       (cnt_dec_s),
    .count_o     (cnt_s),
    .count_nxt_o (cnt_nxt_s),
    .at_zero_o   (cnt_zero_s),
    .borrow_o    (cnt_borrow_s)
  );

  // Next state, output value and status flags.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    err_d    = 1'b0;
    borrow_d = 1'b0;
    done_d   = done_q;
    if (!bus.mode) begin
      state_d = CONV;
      done_d  = 1'b0;
      if (legal_s) begin
        out_d = bin2bcd(MAX_BIN - in_bin_s);
        err_d = 1'b0;
      end else begin
        out_d = 8'h00;
        err_d = 1'b1;
      end
    end else begin
      out_d    = cnt_nxt_s;
      borrow_d = cnt_borrow_s;
      err_d    = counting_s && bus.load && !legal_s;
      if (cnt_load_s) begin
        done_d = 1'b0;
      end else if (stop_s) begin
        done_d = 1'b1;
      end else begin
        done_d = done_q;
      end
      case (state_q)
        CONV: state_d = HALT;
        // done blocks a restart until a load clears it (possibly this cycle).
        HALT: state_d = (bus.en && !done_d) ? RUN : HALT;
        RUN:  state_d = (!bus.en || done_d) ? HALT : RUN;
        default: state_d = CONV;
      endcase
    end
  end

  // State and registered outputs; zero tracks the value being registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CONV;
      out_q    <= 8'h00;
      err_q    <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      err_q    <= err_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      zero_q   <= (out_d == 8'h00);
    end
  end

  assign bus.outdec = out_q.dec;
  assign bus.outuni = out_q.uni;
  assign bus.err    = err_q;
  assign bus.borrow = borrow_q;
  assign bus.done   = done_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_bcd_mod_invcounter.sv
// ---------------------------------------------------------------------------
// tb_bcd_mod_invcounter
// Directed bench for three engine instances sharing one stimulus stream:
//   u24  : MOD=24, WRAP=1
//   u60  : MOD=60, WRAP=1
//   u24s : MOD=24, WRAP=0
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_bcd_mod_invcounter;
  import bcd_mod_invcounter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] code;
  logic       mode, load, en, tick;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  bcd_mod_invcounter_if if24 ();
  bcd_mod_invcounter_if if60 ();
  bcd_mod_invcounter_if if24s ();

  assign if24.code_dec  = code[7:4];
  assign if24.code_uni  = code[3:0];
  assign if24.mode      = mode;
  assign if24.load      = load;
  assign if24.en        = en;
  assign if24.tick      = tick;
  assign if60.code_dec  = code[7:4];
  assign if60.code_uni  = code[3:0];
  assign if60.mode      = mode;
  assign if60.load      = load;
  assign if60.en        = en;
  assign if60.tick      = tick;
  assign if24s.code_dec = code[7:4];
  assign if24s.code_uni = code[3:0];
  assign if24s.mode     = mode;
  assign if24s.load     = load;
  assign if24s.en       = en;
  assign if24s.tick     = tick;

  bcd_mod_invcounter #(.MOD(24), .WRAP(1'b1)) u24  (.clk(clk), .reset(reset), .bus(if24));
  bcd_mod_invcounter #(.MOD(60), .WRAP(1'b1)) u60  (.clk(clk), .reset(reset), .bus(if60));
  bcd_mod_invcounter #(.MOD(24), .WRAP(1'b0)) u24s (.clk(clk), .reset(reset), .bus(if24s));

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs (called just after an edge).
  task automatic drive(input logic [7:0] c, input logic m, input logic l,
                       input logic e, input logic t);
    code = c;
    mode = m;
    load = l;
    en   = e;
    tick = t;
  endtask

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_out",    {if24.outdec, if24.outuni}, 8'h00);
    chk("rst_zero",   {7'd0, if24.zero},   8'h01);
    chk("rst_err",    {7'd0, if24.err},    8'h00);
    chk("rst_borrow", {7'd0, if24.borrow}, 8'h00);
    chk("rst_done",   {7'd0, if24.done},   8'h00);

    // Conversion mode
    drive(8'h07, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("conv24_07",   {if24.outdec, if24.outuni}, 8'h16);
    chk("conv24_07_z", {7'd0, if24.zero}, 8'h00);
    chk("conv24_07_e", {7'd0, if24.err},  8'h00);
    chk("conv60_07",   {if60.outdec, if60.outuni}, 8'h52);
    drive(8'h23, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("conv24_23",   {if24.outdec, if24.outuni}, 8'h00);
    chk("conv24_23_z", {7'd0, if24.zero}, 8'h01);
    chk("conv24_23_e", {7'd0, if24.err},  8'h00);
    chk("conv60_23",   {if60.outdec, if60.outuni}, 8'h36);
    drive(8'h25, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("conv24_25",   {if24.outdec, if24.outuni}, 8'h00);
    chk("conv24_25_e", {7'd0, if24.err},  8'h01);
    chk("conv60_25",   {if60.outdec, if60.outuni}, 8'h34);
    chk("conv60_25_e", {7'd0, if60.err},  8'h00);
    drive(8'h3A, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("conv24_3A",   {if24.outdec, if24.outuni}, 8'h00);
    chk("conv24_3A_e", {7'd0, if24.err},  8'h01);
    chk("conv60_3A_e", {7'd0, if60.err},  8'h01);
    step();
    chk("conv24_3A_e2", {7'd0, if24.err}, 8'h01);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("conv60_00",   {if60.outdec, if60.outuni}, 8'h59);
    chk("conv60_00_e", {7'd0, if60.err},  8'h00);
    chk("conv24_00",   {if24.outdec, if24.outuni}, 8'h23);

    // Count mode, MOD=60 WRAP=1
    drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("cnt60_enter",   {if60.outdec, if60.outuni}, 8'h00);
    chk("cnt60_enter_z", {7'd0, if60.zero}, 8'h01);
    drive(8'h10, 1'b1, 1'b1, 1'b1, 1'b0); step();
    chk("cnt60_load10",  {if60.outdec, if60.outuni}, 8'h10);
    drive(8'h10, 1'b1, 1'b0, 1'b1, 1'b1); step();
    chk("cnt60_tick09",  {if60.outdec, if60.outuni}, 8'h09);
    chk("cnt60_tick09_b", {7'd0, if60.borrow}, 8'h00);
    drive(8'h00, 1'b1, 1'b1, 1'b1, 1'b0); step();
    chk("cnt60_load00",  {if60.outdec, if60.outuni}, 8'h00);
    drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b1); step();
    chk("cnt60_wrap",    {if60.outdec, if60.outuni}, 8'h59);
    chk("cnt60_wrap_b",  {7'd0, if60.borrow}, 8'h01);
    chk("cnt24_wrap",    {if24.outdec, if24.outuni}, 8'h23);
    chk("cnt24_wrap_b",  {7'd0, if24.borrow}, 8'h01);
    chk("cnt24s_00_d",   {7'd0, if24s.done},   8'h01);
    chk("cnt24s_00_b",   {7'd0, if24s.borrow}, 8'h00);
    drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("cnt60_after",   {if60.outdec, if60.outuni}, 8'h59);
    chk("cnt60_after_b", {7'd0, if60.borrow}, 8'h00);

    // Count mode, MOD=24 WRAP=0
    drive(8'h02, 1'b1, 1'b1, 1'b1, 1'b0); step();
    chk("stop_load02",   {if24s.outdec, if24s.outuni}, 8'h02);
    chk("stop_load02_d", {7'd0, if24s.done}, 8'h00);
    drive(8'h02, 1'b1, 1'b0, 1'b1, 1'b1); step();
    chk("stop_t1",       {if24s.outdec, if24s.outuni}, 8'h01);
    chk("stop_t1_d",     {7'd0, if24s.done}, 8'h00);
    step();
    chk("stop_t2",       {if24s.outdec, if24s.outuni}, 8'h00);
    chk("stop_t2_d",     {7'd0, if24s.done}, 8'h01);
    chk("stop_t2_z",     {7'd0, if24s.zero}, 8'h01);
    step();
    chk("stop_t3",       {if24s.outdec, if24s.outuni}, 8'h00);
    chk("stop_t3_d",     {7'd0, if24s.done}, 8'h01);
    chk("stop_t3_b",     {7'd0, if24s.borrow}, 8'h00);
    drive(8'h05, 1'b1, 1'b1, 1'b1, 1'b0); step();
    chk("stop_load05",   {if24s.outdec, if24s.outuni}, 8'h05);
    chk("stop_load05_d", {7'd0, if24s.done}, 8'h00);

    // Load priority, illegal load, tick without enable
    drive(8'h12, 1'b1, 1'b1, 1'b1, 1'b1); step();
    chk("ld_wins",       {if24.outdec, if24.outuni}, 8'h12);
    drive(8'h24, 1'b1, 1'b1, 1'b1, 1'b0); step();
    chk("ld_illegal",    {if24.outdec, if24.outuni}, 8'h12);
    chk("ld_illegal_e",  {7'd0, if24.err}, 8'h01);
    drive(8'h24, 1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("ld_illegal_e0", {7'd0, if24.err}, 8'h00);
    drive(8'h24, 1'b1, 1'b0, 1'b0, 1'b1); step();
    chk("tick_no_en",    {if24.outdec, if24.outuni}, 8'h12);

    // Mode switch keeps the count
    drive(8'h08, 1'b1, 1'b1, 1'b0, 1'b0); step();
    chk("mode_load08",   {if24.outdec, if24.outuni}, 8'h08);
    drive(8'h08, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("mode_conv08",   {if24.outdec, if24.outuni}, 8'h15);
    chk("mode_conv08_60", {if60.outdec, if60.outuni}, 8'h51);
    drive(8'h08, 1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("mode_back08",   {if24.outdec, if24.outuni}, 8'h08);

    // Asynchronous reset mid-run
    drive(8'h15, 1'b1, 1'b1, 1'b1, 1'b0); step();
    chk("arst_pre",      {if24.outdec, if24.outuni}, 8'h15);
    drive(8'h15, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out",      {if24.outdec, if24.outuni}, 8'h00);
    chk("arst_zero",     {7'd0, if24.zero}, 8'h01);
    chk("arst_done",     {7'd0, if24.done}, 8'h00);
    step();
    reset = 1'b0;
    drive(8'h15, 1'b1, 1'b0, 1'b1, 1'b1); step();
    chk("arst_conv",     {if24.outdec, if24.outuni}, 8'h00);
    chk("arst_conv_b",   {7'd0, if24.borrow}, 8'h00);
    chk("arst_conv_e",   {7'd0, if24.err},    8'h00);
    step();
    chk("arst_halt",     {if24.outdec, if24.outuni}, 8'h00);
    chk("arst_halt_b",   {7'd0, if24.borrow}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
